numeric_value_row: RTL

Parametrised numeric display-row generator for the character-based OLED pipeline. It formats a VALUE_WIDTH-bit operand as hex, unsigned decimal, signed decimal or binary into a ROW_CHARS-wide ASCII row. The screen controller reads the row one character at a time by index. Conversion is started by a handshake and computed sequentially, using a multi-cycle double-dabble for the decimal modes. The row is double-buffered, so the screen never shows a partially converted value.

---
 rtl/numeric_row_pkg.sv | 36 +++
 rtl/numeric_value_row_if.sv | 27 ++
 rtl/bcd_double_dabble.sv | 61 ++++++
 rtl/numeric_value_row.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/numeric_row_pkg.sv
// Shared encodings and ASCII constants for the numeric display-row generator.
// Imported by the row interface, the top level and the testbench.
package numeric_row_pkg;

  typedef enum logic [1:0] {
    MODE_HEX  = 2'd0,
    MODE_DEC  = 2'd1,
    MODE_SDEC = 2'd2,
    MODE_BIN  = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ADD3,
    ST_SHIFT,
    ST_COMMIT
  } state_t;

  localparam logic [7:0] ASCII_SPACE      = 8'h20;
  localparam logic [7:0] ASCII_ZERO       = 8'h30;
  localparam logic [7:0] ASCII_ONE        = 8'h31;
  localparam logic [7:0] ASCII_A_MINUS_10 = 8'h37;
  localparam logic [7:0] ASCII_MINUS      = 8'h2D;
  localparam logic [7:0] ASCII_LT         = 8'h3C;

  localparam logic [31:0] LABEL_HEX = "Hex:";
  localparam logic [31:0] LABEL_DEC = "Dec:";
  localparam logic [31:0] LABEL_SGN = "Sgn:";
  localparam logic [31:0] LABEL_BIN = "Bin:";

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? ASCII_ZERO + {4'h0, n} : ASCII_A_MINUS_10 + {4'h0, n};
  endfunction

endpackage

// File: rtl/numeric_value_row_if.sv
// Conversion handshake and character read port between the row generator
// and the screen controller.
interface numeric_value_row_if #(
  parameter int VALUE_WIDTH = 16,
  parameter int ROW_CHARS   = 16
);
  localparam int IDX_W = $clog2(ROW_CHARS);

  logic [VALUE_WIDTH-1:0] value;
  logic [1:0]             mode;
  logic                   start;
  logic                   busy;
  logic                   done;
  logic [IDX_W-1:0]       char_index;
  logic [7:0]             out_byte;

  modport master (
    output value, mode, start, char_index,
    input  busy, done, out_byte
  );

  modport slave (
    input  value, mode, start, char_index,
    output busy, done, out_byte
  );

endinterface

// File: rtl/bcd_double_dabble.sv
// Sequential binary-to-BCD converter: alternates an add-3 step and a shift
// step, VALUE_WIDTH shifts in total; done is high during the final shift.
module bcd_double_dabble #(
  parameter int VALUE_WIDTH = 16,
  parameter int DEC_DIGITS  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [VALUE_WIDTH-1:0]  value,
  output logic                    done,
  output logic [4*DEC_DIGITS-1:0] bcd
);
  localparam int CNT_W = $clog2(VALUE_WIDTH + 1);

  logic [VALUE_WIDTH-1:0]  shreg;
  logic [4*DEC_DIGITS-1:0] bcd_adj;
  logic [CNT_W-1:0]        count;
  logic                    running;
  logic                    add_phase;

  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < DEC_DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) begin
        bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
    end
  end

  assign done = running && !add_phase && (count == CNT_W'(VALUE_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg     <= '0;
      bcd       <= '0;
      count     <= '0;
      running   <= 1'b0;
      add_phase <= 1'b0;
    end else if (start) begin
      shreg     <= value;
      bcd       <= '0;
      count     <= '0;
      running   <= 1'b1;
      add_phase <= 1'b1;
    end else if (running) begin
      if (add_phase) begin
        bcd       <= bcd_adj;
        add_phase <= 1'b0;
      end else begin
        {bcd, shreg} <= {bcd, shreg} << 1;
        count        <= count + 1'b1;
        add_phase    <= 1'b1;
        if (done) begin
          running <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/numeric_value_row.sv
// Formats an operand as hex, decimal, signed decimal or binary into a
// double-buffered ASCII row read one character at a time by index.
module numeric_value_row
  import numeric_row_pkg::*;
#(
  parameter int VALUE_WIDTH = 16,
  parameter int ROW_CHARS   = 16,
  parameter int DEC_DIGITS  = 5
) (
  input logic                clk,
  input logic                reset,
  numeric_value_row_if.slave bus
);
  localparam int IDX_W      = $clog2(ROW_CHARS);
  localparam int AVAIL      = ROW_CHARS - 5;
  localparam int HEX_DIGITS = (VALUE_WIDTH + 3) / 4;
  localparam int HEX_BITS   = 4 * HEX_DIGITS;
  localparam int HEX_SHOW   = (HEX_DIGITS < AVAIL) ? HEX_DIGITS : AVAIL;
  localparam int BIN_SHOW   = (VALUE_WIDTH < AVAIL) ? VALUE_WIDTH : AVAIL;
  localparam int DEC_SHOW   = (DEC_DIGITS < AVAIL) ? DEC_DIGITS : AVAIL;

  state_t                  state, next_state;
  mode_t                   mode_q;
  logic [VALUE_WIDTH-1:0]  val_q;
  logic [VALUE_WIDTH-1:0]  dd_value;
  logic [HEX_BITS-1:0]     hex_val;
  logic [4*DEC_DIGITS-1:0] bcd;
  logic [IDX_W-1:0]        rd_idx;
  logic [7:0]              out_byte_q;
  logic [31:0]             label;
  logic                    neg_q;
  logic                    done_q;
  logic                    dd_start;
  logic                    dd_done;
  logic [7:0]              disp [ROW_CHARS];
  logic [7:0]              row  [ROW_CHARS];
  logic [7:0]              tail [AVAIL];
  int                      sig;
  int                      len;

  assign rd_idx       = bus.char_index;
  assign bus.busy     = (state != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.out_byte = out_byte_q;
  assign hex_val      = HEX_BITS'(val_q);
  assign dd_value     = (mode_q == MODE_SDEC && val_q[VALUE_WIDTH-1]) ? (~val_q) + 1'b1 : val_q;

  bcd_double_dabble #(
    .VALUE_WIDTH (VALUE_WIDTH),
    .DEC_DIGITS  (DEC_DIGITS)
  ) u_dd (
    .clk   (clk),
    .reset (reset),
    .start (dd_start),
    .value (dd_value),
    .done  (dd_done),
    .bcd   (bcd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ADD3/SHIFT run in lockstep with the converter, which flags its last shift.
  always_comb begin
    next_state = state;
    dd_start   = 1'b0;
    unique case (state)
      ST_IDLE:   if (bus.start) next_state = ST_LOAD;
      ST_LOAD: begin
        if (mode_q == MODE_HEX || mode_q == MODE_BIN) begin
          next_state = ST_COMMIT;
        end else begin
          next_state = ST_ADD3;
          dd_start   = 1'b1;
        end
      end
      ST_ADD3:   next_state = ST_SHIFT;
      ST_SHIFT:  next_state = dd_done ? ST_COMMIT : ST_ADD3;
      ST_COMMIT: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // tail[k] is the k-th character counting leftwards from the last column.
  always_comb begin
    for (int k = 0; k < AVAIL; k++) tail[k] = ASCII_SPACE;
    label = LABEL_HEX;
    len   = 0;
    sig   = 1;
    unique case (mode_q)
      MODE_HEX: begin
        len = HEX_DIGITS;
        for (int k = 0; k < HEX_SHOW; k++) tail[k] = hex_char(hex_val[4*k +: 4]);
      end
      MODE_BIN: begin
        label = LABEL_BIN;
        len   = VALUE_WIDTH;
        for (int k = 0; k < BIN_SHOW; k++) tail[k] = val_q[k] ? ASCII_ONE : ASCII_ZERO;
      end
      default: begin
        label = (mode_q == MODE_SDEC) ? LABEL_SGN : LABEL_DEC;
        for (int i = 0; i < DEC_DIGITS; i++) begin
          if (bcd[4*i +: 4] != 4'd0) sig = i + 1;
        end
        for (int k = 0; k < DEC_SHOW; k++) begin
          if (k < sig) tail[k] = ASCII_ZERO + {4'h0, bcd[4*k +: 4]};
        end
        len = neg_q ? sig + 1 : sig;
        for (int k = 0; k < AVAIL; k++) begin
          if (neg_q && k == sig) tail[k] = ASCII_MINUS;
        end
      end
    endcase
    row[0] = label[31:24];
    row[1] = label[23:16];
    row[2] = label[15:8];
    row[3] = label[7:0];
    row[4] = (len > AVAIL) ? ASCII_LT : ASCII_SPACE;
    for (int p = 5; p < ROW_CHARS; p++) row[p] = tail[ROW_CHARS-1-p];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      val_q      <= '0;
      mode_q     <= MODE_HEX;
      neg_q      <= 1'b0;
      done_q     <= 1'b0;
      out_byte_q <= ASCII_SPACE;
      for (int i = 0; i < ROW_CHARS; i++) disp[i] <= ASCII_SPACE;
    end else begin
      done_q     <= (state == ST_COMMIT);
      out_byte_q <= disp[rd_idx];
      if (state == ST_IDLE && bus.start) begin
        val_q  <= bus.value;
        mode_q <= mode_t'(bus.mode);
      end
      if (state == ST_LOAD) begin
        neg_q <= (mode_q == MODE_SDEC) && val_q[VALUE_WIDTH-1];
      end
      if (state == ST_COMMIT) begin
        for (int i = 0; i < ROW_CHARS; i++) disp[i] <= row[i];
      end
    end
  end

endmodule
